cplx_mul_pipe: RTL
==================

// Module: cplx_mul_pipe
// PURPOSE
//   Pipelined, parametrised signed fixed-point complex multiplier Q(W-1) x Q(W-1) -> Q(W-1).
//   Optional per-transaction conjugation of b; selectable rounding; optional saturation.
//   Valid/ready stream block for FFT twiddle and mixer datapaths.
//   Sustains one product per clock when not back-pressured.
// PARAMETERS
//   W       16  component width; signed, W-1 fractional bits (W in 8..32)
//   STAGES  3   pipeline register stages (2..4); see BEHAVIOUR for placement
//   ROUND   1   0: arithmetic-shift truncation; 1: round half up (add 2^(W-2) before >>>(W-1))
// PORTS
//   clk       in   1   clock, rising edge
//   arst      in   1   asynchronous reset, active high
//   in_valid  in   1   input beat valid
//   in_ready  out  1   block can accept input this cycle
//   in_a_re   in   W   operand a, real part
//   in_a_im   in   W   operand a, imaginary part
//   in_b_re   in   W   operand b, real part
//   in_b_im   in   W   operand b, imaginary part
//   in_conj   in   1   1: compute a*conj(b); 0: compute a*b
//   out_valid out  1   result beat valid
//   out_ready in   1   downstream accepts result
//   out_re    out  W   result, real part
//   out_im    out  W   result, imaginary part
//   out_ovf   out  1   result clipped (saturation build only, else 0)
// BEHAVIOUR
//   - Reset (arst=1, async): all stage valid bits and data regs = 0; out_valid=0, out_re=out_im=0, out_ovf=0.
//     in_ready=1 from the first cycle after reset release.
//   - Global stall: adv = !out_valid || out_ready; in_ready = adv (combinational).
//     Every stage register loads only when adv=1. Bubbles are not collapsed.
//   - Transfer: accepted when in_valid && in_ready at a rising edge; stage1 valid <= in_valid when adv.
//   - Latency: result on out_* after STAGES rising edges counting the accept edge (no stall).
//     Throughput is 1 beat per cycle.
//   - While out_valid && !out_ready: out_* and every stage register hold; nothing dropped or duplicated; order preserved.
//   - Stage placement:
//     S1 registers inputs + conj.
//     S2 registers the four 2W-bit products; conj negates b_im before multiply, in 2W-bit width, so -2^(W-1) is exact.
//     S3 (STAGES>=3) registers re = ar*br - ai*bi and im = ar*bi + ai*br in 2W+1 bits.
//     S4 (STAGES==4) registers the rounded/narrowed output.
//     Logic after the last register is combinational to out_*.
//   - Narrowing: t = (sum + (ROUND ? 2^(W-2) : 0)) >>> (W-1), in 2W+1 bits.
//     The result takes the low W bits of t, or the saturated value (CONFIGURATION).
//   - No internal state beyond the pipeline; arst mid-stream discards all in-flight beats immediately.
// CONFIGURATION
//   CPLX_MUL_SAT_EN defined:
//     If t > 2^(W-1)-1, the component = 2^(W-1)-1; if t < -2^(W-1), the component = -2^(W-1).
//     out_ovf=1 with the beat if either component clipped.
//   CPLX_MUL_SAT_EN undefined: components wrap (low W bits of t); out_ovf tied 0.
// TESTING (W=16, STAGES=3, ROUND=1 unless noted)
//   1. a=(0x4000,0), b=(0x4000,0), conj=0 -> out=(0x2000,0x0000), out_valid 3 edges after accept.
//   2. a=(0,0x4000), b=(0,0x4000): conj=0 -> (0xE000,0); conj=1 -> (0x2000,0).
//   3. a=b=(0x8000,0):
//      SAT_EN -> (0x7FFF,0), out_ovf=1.
//      No SAT_EN -> (0x8000,0), out_ovf=0.
//   4. in_valid=1 continuous, 20 beats; out_ready low cycles 5..14.
//      Required: in_ready low exactly while out_valid&&!out_ready, all 20 results in order, none lost or duplicated.
//   5. arst pulsed with 3 beats in flight -> out_valid=0 immediately; no stale beat after release; next beat correct.
//   6. 10k random beats, random stalls, STAGES 2/3/4, ROUND 0/1 vs real model.
//      Where |exact|<1, each component within 1 LSB (ROUND=1 <=0.5 LSB + tie).

Source files
------------

// File: rtl/cplx_mul_pipe.sv
// cplx_mul_pipe: pipelined signed fixed-point complex multiplier, Q(W-1) x Q(W-1) -> Q(W-1).
// Computes a*b, or a*conj(b) when in_conj is set, as a valid/ready stream with a global stall.
// Optional saturation is enabled by defining CPLX_MUL_SAT_EN; otherwise components wrap
// and out_ovf is tied low.
// Pipeline: S1 registers the operands, S2 the four products, S3 (STAGES>=3) the sums and
// S4 (STAGES==4) the narrowed result. Logic after the last register feeds out_* directly.
module cplx_mul_pipe #(
  parameter int W      = 16,
  parameter int STAGES = 3,
  parameter int ROUND  = 1
) (
  input  logic         clk,
  input  logic         arst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a_re,
  input  logic [W-1:0] in_a_im,
  input  logic [W-1:0] in_b_re,
  input  logic [W-1:0] in_b_im,
  input  logic         in_conj,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         out_ovf
);

  localparam int PW = 2 * W;
  localparam int SW = 2 * W + 1;
  localparam logic signed [SW-1:0] RND_ONE = {{(W+2){1'b0}}, 1'b1, {(W-2){1'b0}}};
  localparam logic signed [SW-1:0] RND     = (ROUND != 0) ? RND_ONE : {SW{1'b0}};
`ifdef CPLX_MUL_SAT_EN
  localparam logic signed [SW-1:0] MAXV = {{(W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [SW-1:0] MINV = {{(W+2){1'b1}}, {(W-1){1'b0}}};
`endif

  // Round and shift a (2W+1)-bit sum down to W bits; MSB of the result flags clipping.
  function automatic logic [W:0] narrow(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] t;
    logic [W:0]           res;
    t = (s + RND) >>> (W - 1);
`ifdef CPLX_MUL_SAT_EN
    if (t > MAXV) begin
      res = {1'b1, MAXV[W-1:0]};
    end else if (t < MINV) begin
      res = {1'b1, MINV[W-1:0]};
    end else begin
      res = {1'b0, t[W-1:0]};
    end
`else
    res = {1'b0, t[W-1:0]};
`endif
    return res;
  endfunction

  logic w_adv;

  // Stage 1 registers
  logic         r1_valid;
  logic [W-1:0] r1_ar, r1_ai, r1_br, r1_bi;
  logic         r1_conj;

  // Stage 2 registers and product inputs
  logic                 r2_valid;
  logic signed [PW-1:0] r2_rr, r2_ii, r2_ri, r2_ir;
  logic signed [PW-1:0] w_ar_x, w_ai_x, w_br_x, w_bi_x, w_bi_eff;

  // Sum path and narrowed result
  logic signed [SW-1:0] w_sum_re, w_sum_im;
  logic signed [SW-1:0] w_s_re, w_s_im;
  logic                 w_s_valid;
  logic [W:0]           w_n_re, w_n_im;
  logic                 w_n_ovf;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // Stage 1: capture operands and conjugate flag on every advance.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r1_valid <= 1'b0;
      r1_ar    <= {W{1'b0}};
      r1_ai    <= {W{1'b0}};
      r1_br    <= {W{1'b0}};
      r1_bi    <= {W{1'b0}};
      r1_conj  <= 1'b0;
    end else if (w_adv) begin
      r1_valid <= in_valid;
      r1_ar    <= in_a_re;
      r1_ai    <= in_a_im;
      r1_br    <= in_b_re;
      r1_bi    <= in_b_im;
      r1_conj  <= in_conj;
    end
  end

  // Sign-extend to 2W before negating so that -(-2^(W-1)) is representable.
  assign w_ar_x   = {{W{r1_ar[W-1]}}, r1_ar};
  assign w_ai_x   = {{W{r1_ai[W-1]}}, r1_ai};
  assign w_br_x   = {{W{r1_br[W-1]}}, r1_br};
  assign w_bi_x   = {{W{r1_bi[W-1]}}, r1_bi};
  assign w_bi_eff = r1_conj ? ({PW{1'b0}} - w_bi_x) : w_bi_x;

  // Stage 2: register the four partial products (each fits in 2W signed bits).
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r2_valid <= 1'b0;
      r2_rr    <= {PW{1'b0}};
      r2_ii    <= {PW{1'b0}};
      r2_ri    <= {PW{1'b0}};
      r2_ir    <= {PW{1'b0}};
    end else if (w_adv) begin
      r2_valid <= r1_valid;
      r2_rr    <= w_ar_x * w_br_x;
      r2_ii    <= w_ai_x * w_bi_eff;
      r2_ri    <= w_ar_x * w_bi_eff;
      r2_ir    <= w_ai_x * w_br_x;
    end
  end

  assign w_sum_re = {r2_rr[PW-1], r2_rr} - {r2_ii[PW-1], r2_ii};
  assign w_sum_im = {r2_ri[PW-1], r2_ri} + {r2_ir[PW-1], r2_ir};

  generate
    if (STAGES >= 3) begin : g_s3
      logic                 r3_valid;
      logic signed [SW-1:0] r3_re, r3_im;

      // Stage 3: register the full-precision real and imaginary sums.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          r3_valid <= 1'b0;
          r3_re    <= {SW{1'b0}};
          r3_im    <= {SW{1'b0}};
        end else if (w_adv) begin
          r3_valid <= r2_valid;
          r3_re    <= w_sum_re;
          r3_im    <= w_sum_im;
        end
      end

      assign w_s_valid = r3_valid;
      assign w_s_re    = r3_re;
      assign w_s_im    = r3_im;
    end else begin : g_no_s3
      assign w_s_valid = r2_valid;
      assign w_s_re    = w_sum_re;
      assign w_s_im    = w_sum_im;
    end
  endgenerate

  assign w_n_re  = narrow(w_s_re);
  assign w_n_im  = narrow(w_s_im);
  assign w_n_ovf = w_n_re[W] | w_n_im[W];

  generate
    if (STAGES == 4) begin : g_s4
      logic         r4_valid;
      logic [W-1:0] r4_re, r4_im;
      logic         r4_ovf;

      // Stage 4: register the narrowed output beat.
      always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
          r4_valid <= 1'b0;
          r4_re    <= {W{1'b0}};
          r4_im    <= {W{1'b0}};
          r4_ovf   <= 1'b0;
        end else if (w_adv) begin
          r4_valid <= w_s_valid;
          r4_re    <= w_n_re[W-1:0];
          r4_im    <= w_n_im[W-1:0];
          r4_ovf   <= w_n_ovf;
        end
      end

      assign out_valid = r4_valid;
      assign out_re    = r4_re;
      assign out_im    = r4_im;
      assign out_ovf   = r4_ovf;
    end else begin : g_no_s4
      assign out_valid = w_s_valid;
      assign out_re    = w_n_re[W-1:0];
      assign out_im    = w_n_im[W-1:0];
      assign out_ovf   = w_n_ovf;
    end
  endgenerate

endmodule
